// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART: oversampling constants,
// accumulator width and the TX/RX state encodings.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;
    localparam int ACC_W      = 32;

    // Tick-counter reload values (down-counters, terminal count at zero)
    localparam logic [3:0] BIT_RELOAD = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_RELOAD = 4'(MID_SAMPLE - 1);

    // Legacy-compatible state encodings shared by both directions
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        TX_IDLE   = ST_IDLE,
        TX_START  = ST_START,
        TX_DATA   = ST_DATA,
        TX_PARITY = ST_PARITY,
        TX_STOP   = ST_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = ST_IDLE,
        RX_START  = ST_START,
        RX_DATA   = ST_DATA,
        RX_PARITY = ST_PARITY,
        RX_STOP   = ST_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Fractional baud generator: phase accumulator producing a 16x-oversampling
// tick. baud_rate is sampled every cycle; zero freezes the accumulator.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] baud_rate,
    output logic        tick16
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] sum;

    assign inc    = {4'b0000, baud_rate, 4'b0000};
    assign sum    = acc + inc;
    assign tick16 = (sum >= ACC_W'(CLK_HZ));

    // Advance the accumulator, wrapping by CLK_HZ on every tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (tick16) begin
            acc <= sum - ACC_W'(CLK_HZ);
        end else begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/uart_core_param.sv
// Full-duplex UART core: runtime baud, DATA_BITS data bits, STOP_BITS stop
// bits, valid/ready byte interfaces on both sides.
// Optional parity: define UART_PARITY_EN to insert/check a parity bit
// (sense chosen by PARITY_ODD); undefined gives plain 8N1-style frames.
//
//  state  | meaning
//  IDLE   | TX: ready for a byte     RX: waiting for a falling edge
//  START  | TX: wait tick, send 0    RX: mid-start check (glitch reject)
//  DATA   | shifting data bits LSB first, 16 ticks per bit
//  PARITY | parity bit (UART_PARITY_EN only)
//  STOP   | TX: STOP_BITS stop bits  RX: first stop bit sampled, frame done
module uart_core_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int          DATA_BITS  = 8,
    parameter int          STOP_BITS  = 1,
    parameter int          PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [23:0]          baud_rate,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_ferr,
    output logic                 rx_perr,
    output logic                 rx_overrun
);

    localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

    logic tick16;

    uart_baud_tick #(.CLK_HZ(CLK_HZ)) u_baud (
        .clk       (clk),
        .rst       (rst),
        .baud_rate (baud_rate),
        .tick16    (tick16)
    );

    // ---------------- transmitter ----------------
    tx_state_t            tx_state;
    logic                 tx_pend;
    logic [3:0]           tx_tcnt;
    logic [2:0]           tx_bcnt;
    logic                 tx_scnt;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_line;
`ifdef UART_PARITY_EN
    logic                 tx_par;
`endif

    assign tx_ready = (tx_state == TX_IDLE);
    assign tx       = tx_line;

    // TX FSM; tx_pend holds START until the first tick so bits align to ticks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_pend  <= 1'b0;
            tx_tcnt  <= '0;
            tx_bcnt  <= '0;
            tx_scnt  <= 1'b0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_valid) begin
                        tx_shift <= tx_data;
                        tx_pend  <= 1'b1;
                        tx_state <= TX_START;
`ifdef UART_PARITY_EN
                        tx_par   <= (^tx_data) ^ 1'(PARITY_ODD);
`endif
                    end
                end
                TX_START: begin
                    if (tick16) begin
                        if (tx_pend) begin
                            tx_pend <= 1'b0;
                            tx_line <= 1'b0;
                            tx_tcnt <= BIT_RELOAD;
                        end else if (tx_tcnt == 4'd0) begin
                            tx_line  <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
                            tx_bcnt  <= BIT_LAST;
                            tx_tcnt  <= BIT_RELOAD;
                            tx_state <= TX_DATA;
                        end else begin
                            tx_tcnt <= tx_tcnt - 4'd1;
                        end
                    end
                end
                TX_DATA: begin
                    if (tick16) begin
                        if (tx_tcnt == 4'd0) begin
                            tx_tcnt <= BIT_RELOAD;
                            if (tx_bcnt == 3'd0) begin
`ifdef UART_PARITY_EN
                                tx_line  <= tx_par;
                                tx_state <= TX_PARITY;
`else
                                tx_line  <= 1'b1;
                                tx_scnt  <= STOP_LAST;
                                tx_state <= TX_STOP;
`endif
                            end else begin
                                tx_line  <= tx_shift[0];
                                tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
                                tx_bcnt  <= tx_bcnt - 3'd1;
                            end
                        end else begin
                            tx_tcnt <= tx_tcnt - 4'd1;
                        end
                    end
                end
                TX_PARITY: begin
                    if (tick16) begin
                        if (tx_tcnt == 4'd0) begin
                            tx_line  <= 1'b1;
                            tx_scnt  <= STOP_LAST;
                            tx_tcnt  <= BIT_RELOAD;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_tcnt <= tx_tcnt - 4'd1;
                        end
                    end
                end
                TX_STOP: begin
                    if (tick16) begin
                        if (tx_tcnt == 4'd0) begin
                            if (tx_scnt == 1'b0) begin
                                tx_state <= TX_IDLE;
                            end else begin
                                tx_scnt <= 1'b0;
                                tx_tcnt <= BIT_RELOAD;
                            end
                        end else begin
                            tx_tcnt <= tx_tcnt - 4'd1;
                        end
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    tx_line  <= 1'b1;
                end
            endcase
        end
    end

    // ---------------- receiver ----------------
    rx_state_t            rx_state;
    logic                 rx_s1;
    logic                 rx_s2;
    logic                 rx_prev;
    logic [3:0]           rx_tcnt;
    logic [2:0]           rx_bcnt;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_complete;
`ifdef UART_PARITY_EN
    logic                 rx_par_acc;
    logic                 rx_perr_pend;
`endif

    assign rx_complete = (rx_state == RX_STOP) && tick16 && (rx_tcnt == 4'd0);

    // Two-flop synchroniser plus one delayed copy for start-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // RX FSM; a held-low line after a frame yields no new edge, so a break waits for high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_tcnt  <= '0;
            rx_bcnt  <= '0;
            rx_shift <= '0;
`ifdef UART_PARITY_EN
            rx_par_acc   <= 1'b0;
            rx_perr_pend <= 1'b0;
`endif
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_tcnt  <= MID_RELOAD;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (tick16) begin
                        if (rx_tcnt == 4'd0) begin
                            if (!rx_s2) begin
                                rx_tcnt  <= BIT_RELOAD;
                                rx_bcnt  <= BIT_LAST;
                                rx_state <= RX_DATA;
`ifdef UART_PARITY_EN
                                rx_par_acc <= 1'b0;
`endif
                            end else begin
                                rx_state <= RX_IDLE;
                            end
                        end else begin
                            rx_tcnt <= rx_tcnt - 4'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick16) begin
                        if (rx_tcnt == 4'd0) begin
                            rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                            rx_tcnt  <= BIT_RELOAD;
`ifdef UART_PARITY_EN
                            rx_par_acc <= rx_par_acc ^ rx_s2;
`endif
                            if (rx_bcnt == 3'd0) begin
`ifdef UART_PARITY_EN
                                rx_state <= RX_PARITY;
`else
                                rx_state <= RX_STOP;
`endif
                            end else begin
                                rx_bcnt <= rx_bcnt - 3'd1;
                            end
                        end else begin
                            rx_tcnt <= rx_tcnt - 4'd1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (tick16) begin
                        if (rx_tcnt == 4'd0) begin
`ifdef UART_PARITY_EN
                            rx_perr_pend <= rx_s2 ^ rx_par_acc ^ 1'(PARITY_ODD);
`endif
                            rx_tcnt  <= BIT_RELOAD;
                            rx_state <= RX_STOP;
                        end else begin
                            rx_tcnt <= rx_tcnt - 4'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (tick16) begin
                        if (rx_tcnt == 4'd0) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_tcnt <= rx_tcnt - 4'd1;
                        end
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Output holding register; new frame overwrites and wins over rx_ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_ferr    <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (rx_complete) begin
                rx_data    <= rx_shift;
                rx_ferr    <= ~rx_s2;
                rx_valid   <= 1'b1;
                rx_overrun <= rx_valid & ~rx_ready;
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef UART_PARITY_EN
    // Parity flag travels with the byte it belongs to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_perr <= 1'b0;
        end else if (rx_complete) begin
            rx_perr <= rx_perr_pend;
        end
    end
`else
    assign rx_perr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_core_param.sv
// Scoreboard bench for uart_core_param at 50 MHz / 115200 baud.
// Define UART_PARITY_EN to exercise the parity build.
module tb_uart_core_param;

    localparam int BIT = 434;
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam logic [9:0] A5_BITS = 10'b0101001010;
`else
    localparam int FRAME_BITS = 10;
    localparam logic [9:0] A5_BITS = 10'b1101001010;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] baud_rate;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx;
    logic        rx;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        rx_ferr;
    logic        rx_perr;
    logic        rx_overrun;
    logic        loop;
    logic        rx_drv;

    assign rx = loop ? tx : rx_drv;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks  = 0;
    int   errors  = 0;
    int   ovr_cnt = 0;

    uart_core_param #(
        .CLK_HZ(50000000), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)
    ) dut (
        .clk(clk), .rst(rst), .baud_rate(baud_rate),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx(tx),
        .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_ferr(rx_ferr), .rx_perr(rx_perr), .rx_overrun(rx_overrun)
    );

    always #10 clk = ~clk;

    // Monitor: every consumed byte is popped from the scoreboard and compared
    always @(negedge clk) begin
        if (!rst && rx_valid && rx_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected got data=%h ferr=%b perr=%b, nothing expected",
                         rx_data, rx_ferr, rx_perr);
            end else begin
                mon_e = sb.pop_front();
                if ({rx_data, rx_ferr, rx_perr} !== mon_e) begin
                    errors++;
                    $display("FAIL rx_byte got data=%h ferr=%b perr=%b want data=%h ferr=%b perr=%b",
                             rx_data, rx_ferr, rx_perr, mon_e.data, mon_e.ferr, mon_e.perr);
                end
            end
        end
        if (!rst && rx_overrun) ovr_cnt++;
    end

    initial begin
        #(20 * 95000);
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s got %0d want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic fe, input logic pe);
        exp_t e;
        e.data = d;
        e.ferr = fe;
        e.perr = pe;
        sb.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int c = 0; c < 20000 && !tx_ready; c++) step();
        chk("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
        tx_data  = b;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        chk("tx_ready_drop", {31'd0, tx_ready}, 32'd0);
    endtask

    task automatic wait_tx_start();
        for (int c = 0; c < 300 && tx; c++) step();
        chk("tx_start_seen", {31'd0, tx}, 32'd0);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop_v, input logic par_flip);
        rx_drv = 1'b0;
        repeat (BIT) step();
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (BIT) step();
        end
`ifdef UART_PARITY_EN
        rx_drv = (^b) ^ par_flip;
        repeat (BIT) step();
`endif
        rx_drv = stop_v;
        repeat (BIT) step();
        rx_drv = 1'b1;
        repeat (BIT) step();
    endtask

    task automatic wait_sb(input int budget);
        for (int c = 0; c < budget && sb.size() != 0; c++) step();
        chk("sb_drain", sb.size(), 32'd0);
    endtask

    initial begin
        logic [9:0] bits;
        logic       rdy_bad;
        logic       tx_bad;
        int         idx;
        int         first1;
        int         rise;
        int         base;

        baud_rate = 24'd115200;
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        rx_ready  = 1'b1;
        loop      = 1'b1;
        rx_drv    = 1'b1;
        rst       = 1'b1;
        repeat (5) step();
        rst = 1'b0;
        step();

        chk("rst_tx",         {31'd0, tx},         32'd1);
        chk("rst_tx_ready",   {31'd0, tx_ready},   32'd1);
        chk("rst_rx_valid",   {31'd0, rx_valid},   32'd0);
        chk("rst_rx_data",    {24'd0, rx_data},    32'd0);
        chk("rst_rx_ferr",    {31'd0, rx_ferr},    32'd0);
        chk("rst_rx_perr",    {31'd0, rx_perr},    32'd0);
        chk("rst_rx_overrun", {31'd0, rx_overrun}, 32'd0);

        // 0xA5 on tx, looped back into rx
        push(8'hA5, 1'b0, 1'b0);
        send_byte(8'hA5);
        wait_tx_start();
        bits = '0; rdy_bad = 1'b0; idx = 0; first1 = -1; rise = -1;
        for (int c = 1; c <= 6000; c++) begin
            step();
            if (first1 < 0 && tx) first1 = c;
            if (idx < 10 && c == BIT * idx + BIT / 2) begin
                bits[idx] = tx;
                if (tx_ready) rdy_bad = 1'b1;
                idx++;
            end
            if (tx_ready) begin
                rise = c;
                break;
            end
        end
        for (int i = 0; i < 10; i++)
            chk($sformatf("a5_bit%0d", i), {31'd0, bits[i]}, {31'd0, A5_BITS[i]});
        chk("a5_ready_low", {31'd0, rdy_bad}, 32'd0);
        chk_rng("a5_start_width", first1, BIT - 2, BIT + 2);
        chk_rng("a5_ready_rise", rise, FRAME_BITS * BIT - 4, FRAME_BITS * BIT + 4);
        wait_sb(2000);

        // back-to-back loopback
        push(8'h00, 1'b0, 1'b0);
        send_byte(8'h00);
        push(8'hFF, 1'b0, 1'b0);
        send_byte(8'hFF);
        push(8'h55, 1'b0, 1'b0);
        send_byte(8'h55);
        wait_sb(8000);
        chk("b2b_no_overrun", ovr_cnt, 32'd0);

        // short low glitch rejected, then a real frame
        loop   = 1'b0;
        rx_drv = 1'b0;
        repeat (100) step();
        rx_drv = 1'b1;
        repeat (1000) step();
        chk("glitch_no_valid", {31'd0, rx_valid}, 32'd0);
        push(8'h3C, 1'b0, 1'b0);
        rx_frame(8'h3C, 1'b1, 1'b0);
        wait_sb(2000);

        // stop bit forced low
        push(8'h81, 1'b1, 1'b0);
        rx_frame(8'h81, 1'b0, 1'b0);
        wait_sb(2000);

        // overrun: two frames with nobody consuming
        rx_ready = 1'b0;
        base = ovr_cnt;
        rx_frame(8'h11, 1'b1, 1'b0);
        chk("ovr_first_held", {31'd0, rx_valid}, 32'd1);
        chk("ovr_none_yet", ovr_cnt - base, 32'd0);
        rx_frame(8'h22, 1'b1, 1'b0);
        chk("ovr_pulse_once", ovr_cnt - base, 32'd1);
        chk("ovr_data_kept", {24'd0, rx_data}, 32'h22);
        push(8'h22, 1'b0, 1'b0);
        rx_ready = 1'b1;
        wait_sb(10);
        step();
        chk("ovr_valid_clear", {31'd0, rx_valid}, 32'd0);

        // baud_rate 0 freezes the frame until restored
        loop = 1'b1;
        baud_rate = 24'd0;
        push(8'h5A, 1'b0, 1'b0);
        send_byte(8'h5A);
        tx_bad = 1'b0; rdy_bad = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            step();
            if (!tx) tx_bad = 1'b1;
            if (tx_ready) rdy_bad = 1'b1;
        end
        chk("baud0_tx_idle", {31'd0, tx_bad}, 32'd0);
        chk("baud0_busy", {31'd0, rdy_bad}, 32'd0);
        baud_rate = 24'd115200;
        wait_sb(6000);

        // reset during a data bit
        send_byte(8'h00);
        wait_tx_start();
        repeat (BIT * 2 + 200) step();
        chk("rst_pre_tx_low", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_async_tx", {31'd0, tx}, 32'd1);
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_rel_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_rel_rx_valid", {31'd0, rx_valid}, 32'd0);
        push(8'h12, 1'b0, 1'b0);
        send_byte(8'h12);
        wait_sb(6000);

`ifdef UART_PARITY_EN
        // parity bit on tx, then corrupted parity into rx
        push(8'h07, 1'b0, 1'b0);
        send_byte(8'h07);
        wait_tx_start();
        repeat (BIT * 9 + BIT / 2) step();
        chk("par_tx_bit", {31'd0, tx}, 32'd1);
        wait_sb(6000);
        loop = 1'b0;
        push(8'h07, 1'b0, 1'b1);
        rx_frame(8'h07, 1'b1, 1'b1);
        wait_sb(2000);
`endif

        chk("final_overruns", ovr_cnt, 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
